// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone port arbiter: FSM state and SELECT codes.
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] SEL_REQ1 = 2'b00;
  localparam logic [1:0] SEL_REQ2 = 2'b01;
  localparam logic [1:0] SEL_REQ3 = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

endpackage

// File: rtl/mux_3x1.sv
// Three-input select mux; the unused select code yields zero.
module mux_3x1 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    case (sel)
      2'b00:   out = in_0;
      2'b01:   out = in_1;
      2'b10:   out = in_2;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter funnelling three requesters into one registered,
// backpressured output slot with a wrapping transfer counter.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 REQ_1,
  input  logic                 REQ_2,
  input  logic                 REQ_3,
  input  logic [WIDTH-1:0]     DATA_IN_1,
  input  logic [2:0]           DATA_IN_2,
  input  logic [WIDTH-1:0]     DATA_IN_3,
  output logic                 GNT_1,
  output logic                 GNT_2,
  output logic                 GNT_3,
  output logic [1:0]           SELECT,
  output logic                 OUT_VALID,
  output logic [WIDTH-1:0]     OUT_DATA,
  input  logic                 OUT_READY,
  output logic [CNT_WIDTH-1:0] XFER_COUNT
);

  state_t               state_reg;
  logic [1:0]           last_reg;
  logic [1:0]           select_reg;
  logic                 valid_reg;
  logic [WIDTH-1:0]     data_reg;
  logic [CNT_WIDTH-1:0] count_reg;

  logic [1:0]       winner;
  logic             capture;
  logic             take;
  logic             accept;
  logic [2:0]       gnt_vec;
  logic [WIDTH-1:0] mux_out;

  assign capture = (state_reg == IDLE) || OUT_READY;
  assign accept  = (state_reg == BUSY) && OUT_READY;
  assign take    = capture && (winner != SEL_NONE);

  // Search starts just after the previous winner so nobody waits more than 3 captures.
  always_comb begin
    winner = SEL_NONE;
    case (last_reg)
      SEL_REQ1: begin
        if (REQ_2)      winner = SEL_REQ2;
        else if (REQ_3) winner = SEL_REQ3;
        else if (REQ_1) winner = SEL_REQ1;
      end
      SEL_REQ2: begin
        if (REQ_3)      winner = SEL_REQ3;
        else if (REQ_1) winner = SEL_REQ1;
        else if (REQ_2) winner = SEL_REQ2;
      end
      default: begin
        if (REQ_1)      winner = SEL_REQ1;
        else if (REQ_2) winner = SEL_REQ2;
        else if (REQ_3) winner = SEL_REQ3;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_gnt
      assign gnt_vec[gi] = take && !RESET && (winner == 2'(gi));
    end
  endgenerate

  assign GNT_1 = gnt_vec[0];
  assign GNT_2 = gnt_vec[1];
  assign GNT_3 = gnt_vec[2];

  mux_3x1 #(.WIDTH(WIDTH)) u_payload_mux (
    .sel  (winner),
    .in_0 (DATA_IN_1),
    .in_1 ({{(WIDTH-3){1'b0}}, DATA_IN_2}),
    .in_2 (DATA_IN_3),
    .out  (mux_out)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg  <= IDLE;
      last_reg   <= SEL_REQ3;
      select_reg <= SEL_NONE;
      valid_reg  <= 1'b0;
      data_reg   <= '0;
      count_reg  <= '0;
    end else begin
      if (accept) begin
        count_reg <= count_reg + CNT_WIDTH'(1);
      end
      if (take) begin
        state_reg  <= BUSY;
        last_reg   <= winner;
        select_reg <= winner;
        valid_reg  <= 1'b1;
        data_reg   <= mux_out;
      end else if (accept) begin
        // Slot drained with nobody waiting: OUT_DATA keeps its last value.
        state_reg  <= IDLE;
        select_reg <= SEL_NONE;
        valid_reg  <= 1'b0;
      end
    end
  end

  assign SELECT     = select_reg;
  assign OUT_VALID  = valid_reg;
  assign OUT_DATA   = data_reg;
  assign XFER_COUNT = count_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter (narrow counter to reach wrap quickly).
module tb_wb_port_arbiter;

  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 4;

  logic                 CLK = 1'b0;
  logic                 RESET;
  logic                 REQ_1, REQ_2, REQ_3;
  logic [WIDTH-1:0]     DATA_IN_1, DATA_IN_3;
  logic [2:0]           DATA_IN_2;
  logic                 GNT_1, GNT_2, GNT_3;
  logic [1:0]           SELECT;
  logic                 OUT_VALID;
  logic [WIDTH-1:0]     OUT_DATA;
  logic                 OUT_READY;
  logic [CNT_WIDTH-1:0] XFER_COUNT;

  always #5 CLK = ~CLK;

  wb_port_arbiter #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .REQ_1      (REQ_1),
    .REQ_2      (REQ_2),
    .REQ_3      (REQ_3),
    .DATA_IN_1  (DATA_IN_1),
    .DATA_IN_2  (DATA_IN_2),
    .DATA_IN_3  (DATA_IN_3),
    .GNT_1      (GNT_1),
    .GNT_2      (GNT_2),
    .GNT_3      (GNT_3),
    .SELECT     (SELECT),
    .OUT_VALID  (OUT_VALID),
    .OUT_DATA   (OUT_DATA),
    .OUT_READY  (OUT_READY),
    .XFER_COUNT (XFER_COUNT)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  req;      // {REQ_3, REQ_2, REQ_1}
    logic [31:0] d1;
    logic [2:0]  d2;
    logic [31:0] d3;
    logic        ready;
    logic [2:0]  gnt;      // expected {GNT_3, GNT_2, GNT_1} during the cycle
    logic        valid;    // expected registered outputs after the edge
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [2:0] req, input logic [31:0] d1,
                     input logic [2:0] d2, input logic [31:0] d3, input logic ready,
                     input logic [2:0] gnt, input logic valid, input logic [1:0] sel,
                     input logic [31:0] data, input logic [3:0] cnt);
    vec_t v;
    v.rst = rst; v.req = req; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.ready = ready;
    v.gnt = gnt; v.valid = valid; v.sel = sel; v.data = data; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] A1 = 32'hA1A1A1A1;
  localparam logic [31:0] C3 = 32'hC3C3C3C3;
  localparam logic [31:0] NX = 32'h12345678;

  initial begin
    RESET = 1'b1; REQ_1 = 0; REQ_2 = 0; REQ_3 = 0;
    DATA_IN_1 = '0; DATA_IN_2 = '0; DATA_IN_3 = '0; OUT_READY = 0;

    //  rst req     d1  d2      d3  rdy gnt     v  sel    data         cnt
    add(1, 3'b000, DB, 3'b000, C3, 0, 3'b000, 0, 2'b11, 32'h0,       4'd0);  // reset state
    add(1, 3'b111, DB, 3'b000, C3, 0, 3'b000, 0, 2'b11, 32'h0,       4'd0);  // no GNT in reset
    add(0, 3'b001, DB, 3'b000, C3, 1, 3'b001, 1, 2'b00, DB,          4'd0);  // single request
    add(0, 3'b000, DB, 3'b000, C3, 1, 3'b000, 0, 2'b11, DB,          4'd1);  // drain to IDLE
    add(0, 3'b010, DB, 3'b101, C3, 0, 3'b010, 1, 2'b01, 32'h5,       4'd1);  // zero-extend
    add(0, 3'b000, DB, 3'b101, C3, 1, 3'b000, 0, 2'b11, 32'h5,       4'd2);
    add(0, 3'b000, DB, 3'b101, C3, 1, 3'b000, 0, 2'b11, 32'h5,       4'd2);  // ready ignored idle
    add(1, 3'b000, A1, 3'b011, C3, 0, 3'b000, 0, 2'b11, 32'h0,       4'd0);
    add(0, 3'b111, A1, 3'b011, C3, 1, 3'b001, 1, 2'b00, A1,          4'd0);  // fairness
    add(0, 3'b111, A1, 3'b011, C3, 1, 3'b010, 1, 2'b01, 32'h3,       4'd1);
    add(0, 3'b111, A1, 3'b011, C3, 1, 3'b100, 1, 2'b10, C3,          4'd2);
    add(0, 3'b111, A1, 3'b011, C3, 1, 3'b001, 1, 2'b00, A1,          4'd3);
    add(0, 3'b111, A1, 3'b011, C3, 1, 3'b010, 1, 2'b01, 32'h3,       4'd4);
    add(0, 3'b111, A1, 3'b011, C3, 1, 3'b100, 1, 2'b10, C3,          4'd5);
    add(0, 3'b100, A1, 3'b011, NX, 0, 3'b000, 1, 2'b10, C3,          4'd5);  // backpressure
    add(0, 3'b000, A1, 3'b011, NX, 0, 3'b000, 1, 2'b10, C3,          4'd5);
    add(0, 3'b100, A1, 3'b011, NX, 0, 3'b000, 1, 2'b10, C3,          4'd5);
    add(0, 3'b000, A1, 3'b011, NX, 0, 3'b000, 1, 2'b10, C3,          4'd5);
    add(0, 3'b100, A1, 3'b011, NX, 1, 3'b100, 1, 2'b10, NX,          4'd6);  // back-to-back
    add(0, 3'b000, A1, 3'b011, NX, 0, 3'b000, 1, 2'b10, NX,          4'd6);
    add(1, 3'b111, A1, 3'b011, NX, 1, 3'b000, 0, 2'b11, 32'h0,       4'd0);  // mid-transfer reset
    add(0, 3'b111, A1, 3'b011, NX, 0, 3'b001, 1, 2'b00, A1,          4'd0);  // req1 first
    add(0, 3'b000, A1, 3'b011, NX, 1, 3'b000, 0, 2'b11, A1,          4'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      RESET = vecs[i].rst;
      {REQ_3, REQ_2, REQ_1} = vecs[i].req;
      DATA_IN_1 = vecs[i].d1; DATA_IN_2 = vecs[i].d2; DATA_IN_3 = vecs[i].d3;
      OUT_READY = vecs[i].ready;
      #1;
      check($sformatf("v%0d gnt", i), {29'd0, GNT_3, GNT_2, GNT_1}, {29'd0, vecs[i].gnt});
      @(posedge CLK); #1;
      check($sformatf("v%0d valid", i), {31'd0, OUT_VALID}, {31'd0, vecs[i].valid});
      check($sformatf("v%0d select", i), {30'd0, SELECT}, {30'd0, vecs[i].sel});
      check($sformatf("v%0d data", i), OUT_DATA, vecs[i].data);
      check($sformatf("v%0d count", i), {28'd0, XFER_COUNT}, {28'd0, vecs[i].cnt});
      $display("vec %0d: req=%b rdy=%b gnt=%b valid=%b sel=%b data=%h cnt=%0d",
               i, vecs[i].req, vecs[i].ready, {GNT_3, GNT_2, GNT_1}, OUT_VALID, SELECT,
               OUT_DATA, XFER_COUNT);
    end

    // Counter wrap: 17 accepted transfers on a 4-bit counter land on 1.
    @(negedge CLK);
    RESET = 1'b1; {REQ_3, REQ_2, REQ_1} = 3'b000; OUT_READY = 1'b0;
    @(posedge CLK); #1;
    check("wrap reset count", {28'd0, XFER_COUNT}, 32'd0);
    for (int i = 1; i <= 18; i++) begin
      @(negedge CLK);
      RESET = 1'b0; REQ_1 = 1'b1; OUT_READY = 1'b1; DATA_IN_1 = 32'(i);
      #1;
      check($sformatf("wrap%0d gnt", i), {29'd0, GNT_3, GNT_2, GNT_1}, 32'd1);
      @(posedge CLK); #1;
      check($sformatf("wrap%0d count", i), {28'd0, XFER_COUNT}, 32'((i - 1) % 16));
      $display("wrap %0d: sel=%b data=%h cnt=%0d", i, SELECT, OUT_DATA, XFER_COUNT);
    end
    check("wrap final count", {28'd0, XFER_COUNT}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
